// File: rtl/pool_unit.sv
// Per-lane pooling datapath: gathers a 2x2 or 3x3 window of signed elements
// and reduces it to the maximum or the truncated-toward-zero average.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; strobes here are dropped and flagged
// S_ACCUM | collecting window elements, running sum and running max
// S_DIV   | avg9 only: bit-serial restoring divide of |sum| by 9
// S_HOLD  | result valid, waiting for out_pipe_en to pop it
module pool_unit #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = DATA_W + 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              max_avg,
  input  logic              win9,
  input  logic              in_pipe_en,
  input  logic [DATA_W-1:0] data_in,
  input  logic              out_pipe_en,
  output logic [DATA_W-1:0] result,
  output logic              res_valid,
  output logic              busy,
  output logic              drop_err
);

  localparam int CNT_W = $clog2(ACC_W + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DIV   = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  logic [1:0]               state;
  logic                     mode_max;
  logic                     mode_9;
  logic [3:0]               cnt;
  logic signed [ACC_W-1:0]  acc;
  logic signed [DATA_W-1:0] run_max;
  logic [ACC_W-1:0]         div_sh;
  logic [3:0]               div_rem;
  logic [CNT_W-1:0]         div_cnt;
  logic                     div_neg;

  logic signed [ACC_W-1:0]  data_ext;
  logic signed [ACC_W-1:0]  acc_nxt;
  logic signed [DATA_W-1:0] data_s;
  logic signed [DATA_W-1:0] max_nxt;
  logic                     last_elem;
  logic [ACC_W-1:0]         acc_abs;
  logic [DATA_W-1:0]        avg4_mag;
  logic [DATA_W-1:0]        avg4_val;
  logic [4:0]               rem_sh;
  logic [4:0]               rem_diff;
  logic                     q_bit;
  logic [3:0]               rem_nxt;
  logic [ACC_W-1:0]         sh_nxt;
  logic [DATA_W-1:0]        q_low;
  logic [DATA_W-1:0]        div_res;

  // Window arithmetic: next sum, next max, window-complete detect and avg4.
  always_comb begin
    data_s    = data_in;
    data_ext  = {{(ACC_W-DATA_W){data_in[DATA_W-1]}}, data_in};
    acc_nxt   = acc + data_ext;
    max_nxt   = (data_s > run_max) ? data_s : run_max;
    last_elem = (cnt == (mode_9 ? 4'd8 : 4'd3));
    acc_abs   = acc_nxt[ACC_W-1] ? -acc_nxt : acc_nxt;
    avg4_mag  = acc_abs[DATA_W+1:2];
    avg4_val  = acc_nxt[ACC_W-1] ? -avg4_mag : avg4_mag;
  end

  // One restoring-divide step by 9; the quotient bit shifts into div_sh's LSB
  // so after ACC_W steps div_sh holds the full quotient.
  always_comb begin
    rem_sh   = {div_rem, div_sh[ACC_W-1]};
    rem_diff = rem_sh - 5'd9;
    q_bit    = (rem_sh >= 5'd9);
    rem_nxt  = q_bit ? rem_diff[3:0] : rem_sh[3:0];
    sh_nxt   = {div_sh[ACC_W-2:0], q_bit};
    q_low    = sh_nxt[DATA_W-1:0];
    div_res  = div_neg ? -q_low : q_low;
  end

  assign res_valid = (state == S_HOLD);
  assign busy      = (state != S_IDLE);

  // Control FSM and datapath registers; start aborts from any state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      mode_max <= 1'b0;
      mode_9   <= 1'b0;
      cnt      <= '0;
      acc      <= '0;
      run_max  <= '0;
      div_sh   <= '0;
      div_rem  <= '0;
      div_cnt  <= '0;
      div_neg  <= 1'b0;
      result   <= '0;
      drop_err <= 1'b0;
    end else begin
      if (in_pipe_en && !start && state != S_ACCUM)
        drop_err <= 1'b1;
      if (start) begin
        state    <= S_ACCUM;
        mode_max <= max_avg;
        mode_9   <= win9;
        cnt      <= '0;
        acc      <= '0;
        run_max  <= {1'b1, {(DATA_W-1){1'b0}}};
        drop_err <= 1'b0;
      end else begin
        case (state)
          S_ACCUM: begin
            if (in_pipe_en) begin
              acc     <= acc_nxt;
              run_max <= max_nxt;
              cnt     <= cnt + 4'd1;
              if (last_elem) begin
                if (mode_max) begin
                  result <= max_nxt;
                  state  <= S_HOLD;
                end else if (!mode_9) begin
                  result <= avg4_val;
                  state  <= S_HOLD;
                end else begin
                  div_sh  <= acc_abs;
                  div_rem <= '0;
                  div_cnt <= CNT_W'(ACC_W - 1);
                  div_neg <= acc_nxt[ACC_W-1];
                  state   <= S_DIV;
                end
              end
            end
          end
          S_DIV: begin
            div_sh  <= sh_nxt;
            div_rem <= rem_nxt;
            div_cnt <= div_cnt - 1'b1;
            if (div_cnt == '0) begin
              result <= div_res;
              state  <= S_HOLD;
            end
          end
          S_HOLD: begin
            if (out_pipe_en)
              state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/pool_unit.md
Name: pool_unit

Overview:
Per-lane pooling datapath that consumes the element stream issued by the pooling controller. It collects one window of 4 (2x2) or 9 (3x3) signed elements, one element per in_pipe_en strobe, and reduces the window to its maximum or its average. The result is held in an output register until the controller's out_pipe_en acknowledges it. One instance sits per pooling lane, directly downstream of the pooling controller.

Parameters:
DATA_W, 16, element and result width in bits, two's-complement signed
ACC_W, DATA_W+4, accumulator width in bits; wide enough for 9 elements without overflow

Ports:
clk  in  1  clock; all state updates on its rising edge
rst  in  1  reset, synchronous, active-high
start  in  1  one-cycle pulse that begins a new window and latches max_avg and win9
max_avg  in  1  operation select: 1 = max, 0 = average; sampled only on start
win9  in  1  window size: 1 = 9 elements, 0 = 4 elements; sampled only on start
in_pipe_en  in  1  element strobe; data_in is valid this cycle
data_in  in  DATA_W  signed window element
out_pipe_en  in  1  result acknowledge / pop
result  out  DATA_W  signed pooled value; stable while res_valid is high
res_valid  out  1  result register holds an unconsumed value
busy  out  1  high in ACCUM, DIV and HOLD
drop_err  out  1  sticky: an element was strobed outside ACCUM

Behaviour:
- Reset (rst=1 at a clock edge): state IDLE; result=0, res_valid=0, busy=0, drop_err=0, element counter=0, accumulator=0. Reset wins over every other input in the same cycle, including mid-window and mid-divide.
- States:
  - IDLE: start -> ACCUM. Latch mode, clear counter, clear accumulator, set running max to the most negative value, clear drop_err. An in_pipe_en in the same cycle as start is not accumulated and does not set drop_err.
  - ACCUM: each in_pipe_en adds sign-extended data_in to the accumulator and updates the running max (signed compare, ties keep the current max). The counter increments.
    - On the strobe that completes the window (4th or 9th element):
      - max, avg4: result written at that edge; go to HOLD.
      - avg9: go to DIV.
    - Cycles without in_pipe_en: hold all state; there is no timeout.
  - DIV (avg9 only): restoring divide of |sum| by 9, one quotient bit per cycle, ACC_W cycles. Then result = quotient with the sum's sign reapplied, truncated to DATA_W; go to HOLD.
  - HOLD: res_valid=1. out_pipe_en -> IDLE and res_valid falls at that edge. result keeps its value until it is next written.
- Average rounding: truncation toward zero for both window sizes. avg4 = sign(sum) * (|sum| >> 2); avg9 = sign(sum) * floor(|sum| / 9). The true average always fits in DATA_W, so no saturation logic.
- Latency, with the last element strobed in cycle T:
  - max, avg4: res_valid high from cycle T+1.
  - avg9: res_valid high from cycle T+1+ACC_W (T+21 at default parameters).
- Boundary conditions:
  - start in ACCUM, DIV or HOLD aborts the current window: res_valid drops, partial work is discarded, and a fresh window begins (same as start from IDLE).
  - in_pipe_en in IDLE (without start), DIV or HOLD: element discarded, drop_err set. drop_err clears only on start or rst.
  - out_pipe_en outside HOLD: ignored.
  - out_pipe_en and start in the same HOLD cycle: start wins; result is popped and the new window begins.
  - in_pipe_en and out_pipe_en in the same HOLD cycle: element dropped (drop_err=1), then pop to IDLE.
  - Counter is 4 bits and saturates at window completion; it never wraps.
  - Mode inputs are ignored except on start; changing them mid-window has no effect.

Test Plan:
- Max, 2x2, elements 3, -7, 12, 12 -> result=12 with res_valid one cycle after the 4th strobe; out_pipe_en -> res_valid=0, busy=0.
- Avg, 2x2, elements -1, -2, -2, 0 (sum -5) -> result=-1 (truncation toward zero), latency 1 cycle.
- Avg, 3x3, elements 100 x8 and 101 (sum 901) -> result=100 exactly 21 cycles after the last strobe. Repeat with all -32768 -> result=-32768.
- Max, 3x3, all elements -32768, with 2-cycle gaps between strobes -> result=-32768; busy stays high throughout the gaps.
- Abort and errors: start after 2 of 4 elements, then feed 4 elements of 5 -> result=5 (avg4); strobe one element during HOLD -> drop_err=1 until the next start.
- rst asserted mid-DIV -> next cycle all outputs 0 and state IDLE; a subsequent max window of 1, 2, 3, 4 -> result=4.
